// File: rtl/int2float_pkg.sv
// Shared types, constants and helpers for the pipelined integer-to-float converter.
package int2float_pkg;

    typedef enum logic {
        RND_TRUNC = 1'b0,
        RND_RNE   = 1'b1
    } rnd_mode_e;

    localparam int unsigned CNT_W = 16;

    function automatic int unsigned out_width(input int unsigned is_signed,
                                              input int unsigned exp_w,
                                              input int unsigned man_w);
        return is_signed + exp_w + man_w;
    endfunction

endpackage

// File: rtl/int2float_lzc.sv
// Combinational leading-one detector: index of the most significant set bit.
module int2float_lzc
    import int2float_pkg::*;
#(
    parameter int unsigned W = 11,
    localparam int unsigned IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  value,
    output logic [IW-1:0] msb_idx,
    output logic          zero
);

    // Ascending scan: the last set bit seen is the MSB.
    always_comb begin
        msb_idx = '0;
        zero    = 1'b1;
        for (int unsigned i = 0; i < W; i++) begin
            if (value[i]) begin
                msb_idx = IW'(i);
                zero    = 1'b0;
            end
        end
    end

endmodule

// File: rtl/int2float_pipe.sv
// Three-stage integer-to-float converter (sign/magnitude, normalise, round/pack)
// behind a valid/ready stream; all stages advance or freeze together.
module int2float_pipe
    import int2float_pkg::*;
#(
    parameter int unsigned IN_W   = 11,
    parameter int unsigned EXP_W  = 4,
    parameter int unsigned MAN_W  = 3,
    parameter int unsigned SIGNED = 0,
    localparam int unsigned OUT_W = out_width(SIGNED, EXP_W, MAN_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_rnd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_zero,
    output logic             out_inexact,
    output logic             out_ovf,
    output logic [CNT_W-1:0] conv_count
);

    localparam int unsigned PW = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int unsigned FW = IN_W - 1;
    // Internal exponent is wide enough for p+1 plus a rounding carry, and for EXP_MAX.
    localparam int unsigned XW = (EXP_W > $clog2(IN_W + 2)) ? EXP_W + 1 : $clog2(IN_W + 2) + 1;
    localparam logic [XW-1:0] EXP_MAX = {{(XW - EXP_W){1'b0}}, {EXP_W{1'b1}}};

    logic advance;

    // Stage 1: sign/magnitude
    logic            s1_valid_d, s1_valid_q;
    logic            s1_sign_d, s1_sign_q;
    logic [IN_W-1:0] s1_mag_d, s1_mag_q;
    rnd_mode_e       s1_rnd_d, s1_rnd_q;

    // Stage 2: normalised fraction
    logic            s2_valid_d, s2_valid_q;
    logic            s2_sign_d, s2_sign_q;
    logic            s2_zero_d, s2_zero_q;
    logic [PW-1:0]   s2_p_d, s2_p_q;
    logic [FW-1:0]   s2_frac_d, s2_frac_q;
    rnd_mode_e       s2_rnd_d, s2_rnd_q;

    // Stage 3: packed result
    logic             out_valid_d, out_valid_q;
    logic [OUT_W-1:0] out_data_d, out_data_q;
    logic             out_zero_d, out_zero_q;
    logic             out_inexact_d, out_inexact_q;
    logic             out_ovf_d, out_ovf_q;
    logic [CNT_W-1:0] conv_count_d, conv_count_q;

    assign advance  = out_ready | ~out_valid_q;
    assign in_ready = advance;

    // Stage 1 combinational: the most negative value negates to 2^(IN_W-1) unsigned.
    logic            in_sign;
    logic [IN_W-1:0] in_mag;

    always_comb begin
        in_sign = (SIGNED != 0) && in_data[IN_W-1];
        in_mag  = in_sign ? (~in_data + IN_W'(1)) : in_data;
    end

    // Stage 2 combinational: locate MSB and shift it out above the fraction.
    logic [PW-1:0] lzc_idx;
    logic          lzc_zero;
    logic [PW-1:0] norm_shift;

    int2float_lzc #(
        .W(IN_W)
    ) u_lzc (
        .value   (s1_mag_q),
        .msb_idx (lzc_idx),
        .zero    (lzc_zero)
    );

    assign norm_shift = PW'(IN_W - 1) - lzc_idx;

    // Stage 3 combinational: round and pack.
    logic [IN_W:0]          frac_ext;
    logic [MAN_W-1:0]       mant_raw;
    logic                   guard_bit;
    logic                   sticky_bit;
    logic                   round_up;
    logic [MAN_W:0]         mant_sum;
    logic [XW-1:0]          exp_rnd;
    logic                   pk_sign;
    logic [EXP_W-1:0]       pk_exp;
    logic [MAN_W-1:0]       pk_mant;
    logic                   pk_inexact;
    logic                   pk_ovf;
    logic [EXP_W+MAN_W:0]   pack_full;
    logic [OUT_W-1:0]       pack;

    always_comb begin
        frac_ext   = {s2_frac_q, 2'b00};
        mant_raw   = frac_ext[IN_W -: MAN_W];
        guard_bit  = frac_ext[IN_W - MAN_W];
        sticky_bit = |frac_ext[IN_W - MAN_W - 1:0];
        round_up   = (s2_rnd_q == RND_RNE) & guard_bit & (sticky_bit | mant_raw[0]);
        mant_sum   = {1'b0, mant_raw} + {{MAN_W{1'b0}}, round_up};
        exp_rnd    = XW'(s2_p_q) + XW'(1) + XW'(mant_sum[MAN_W]);

        pk_sign    = 1'b0;
        pk_exp     = '0;
        pk_mant    = '0;
        pk_inexact = 1'b0;
        pk_ovf     = 1'b0;
        if (!s2_zero_q) begin
            pk_sign = s2_sign_q;
            if (exp_rnd > EXP_MAX) begin
                pk_exp     = '1;
                pk_mant    = '1;
                pk_inexact = 1'b1;
                pk_ovf     = 1'b1;
            end else begin
                pk_exp     = exp_rnd[EXP_W-1:0];
                pk_mant    = mant_sum[MAN_W-1:0];
                pk_inexact = guard_bit | sticky_bit;
            end
        end
        pack_full = {pk_sign, pk_exp, pk_mant};
    end

    if (SIGNED != 0) begin : g_signed
        assign pack = pack_full;
    end else begin : g_unsigned
        logic unused_sign;
        assign unused_sign = pack_full[OUT_W];
        assign pack        = pack_full[OUT_W-1:0];
    end

    // Next-state: every stage captures only when advancing and its source is valid.
    always_comb begin
        s1_valid_d    = s1_valid_q;
        s1_sign_d     = s1_sign_q;
        s1_mag_d      = s1_mag_q;
        s1_rnd_d      = s1_rnd_q;
        s2_valid_d    = s2_valid_q;
        s2_sign_d     = s2_sign_q;
        s2_zero_d     = s2_zero_q;
        s2_p_d        = s2_p_q;
        s2_frac_d     = s2_frac_q;
        s2_rnd_d      = s2_rnd_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_zero_d    = out_zero_q;
        out_inexact_d = out_inexact_q;
        out_ovf_d     = out_ovf_q;
        conv_count_d  = conv_count_q;

        if (advance) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_sign_d = in_sign;
                s1_mag_d  = in_mag;
                s1_rnd_d  = rnd_mode_e'(in_rnd);
            end

            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_sign_d = s1_sign_q;
                s2_zero_d = lzc_zero;
                s2_p_d    = lzc_idx;
                s2_frac_d = FW'(s1_mag_q << norm_shift);
                s2_rnd_d  = s1_rnd_q;
            end

            out_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                out_data_d    = pack;
                out_zero_d    = s2_zero_q;
                out_inexact_d = pk_inexact;
                out_ovf_d     = pk_ovf;
            end
        end

        if (out_valid_q && out_ready) begin
            conv_count_d = conv_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q    <= 1'b0;
            s1_sign_q     <= 1'b0;
            s1_mag_q      <= '0;
            s1_rnd_q      <= RND_TRUNC;
            s2_valid_q    <= 1'b0;
            s2_sign_q     <= 1'b0;
            s2_zero_q     <= 1'b0;
            s2_p_q        <= '0;
            s2_frac_q     <= '0;
            s2_rnd_q      <= RND_TRUNC;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_zero_q    <= 1'b0;
            out_inexact_q <= 1'b0;
            out_ovf_q     <= 1'b0;
            conv_count_q  <= '0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_sign_q     <= s1_sign_d;
            s1_mag_q      <= s1_mag_d;
            s1_rnd_q      <= s1_rnd_d;
            s2_valid_q    <= s2_valid_d;
            s2_sign_q     <= s2_sign_d;
            s2_zero_q     <= s2_zero_d;
            s2_p_q        <= s2_p_d;
            s2_frac_q     <= s2_frac_d;
            s2_rnd_q      <= s2_rnd_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_zero_q    <= out_zero_d;
            out_inexact_q <= out_inexact_d;
            out_ovf_q     <= out_ovf_d;
            conv_count_q  <= conv_count_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_zero    = out_zero_q;
    assign out_inexact = out_inexact_q;
    assign out_ovf     = out_ovf_q;
    assign conv_count  = conv_count_q;

endmodule

// File: tb/tb_int2float_pipe.sv
// Scoreboard bench for int2float_pipe: default, narrow-exponent and signed instances.
module tb_int2float_pipe;
    import int2float_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [10:0] in_data;
    logic        in_rnd;
    logic        out_ready;

    logic        m_in_ready, m_out_valid, m_zero, m_inexact, m_ovf;
    logic [6:0]  m_out_data;
    logic [15:0] m_cnt;
    logic        s_in_ready, s_out_valid, s_zero, s_inexact, s_ovf;
    logic [5:0]  s_out_data;
    logic [15:0] s_cnt;
    logic        g_in_ready, g_out_valid, g_zero, g_inexact, g_ovf;
    logic [7:0]  g_out_data;
    logic [15:0] g_cnt;

    int2float_pipe u_dut_m (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(m_in_ready),
        .in_data(in_data), .in_rnd(in_rnd), .out_valid(m_out_valid), .out_ready(out_ready),
        .out_data(m_out_data), .out_zero(m_zero), .out_inexact(m_inexact), .out_ovf(m_ovf),
        .conv_count(m_cnt)
    );

    int2float_pipe #(.EXP_W(3)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .in_rnd(in_rnd), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_data(s_out_data), .out_zero(s_zero), .out_inexact(s_inexact), .out_ovf(s_ovf),
        .conv_count(s_cnt)
    );

    int2float_pipe #(.SIGNED(1)) u_dut_g (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(g_in_ready),
        .in_data(in_data), .in_rnd(in_rnd), .out_valid(g_out_valid), .out_ready(out_ready),
        .out_data(g_out_data), .out_zero(g_zero), .out_inexact(g_inexact), .out_ovf(g_ovf),
        .conv_count(g_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       zero;
        logic       inexact;
        logic       ovf;
        int         stamp;
    } exp_t;

    typedef struct packed {
        logic       valid;
        logic [7:0] data;
        logic       zero;
        logic       inexact;
        logic       ovf;
    } obs_t;

    exp_t q_m[$];
    exp_t q_s[$];
    exp_t q_g[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;

    // Reference for the default instance (unsigned, EXP_W=4, MAN_W=3), by integer arithmetic.
    function automatic exp_t model(input logic [10:0] v, input logic rnd, input int stamp);
        exp_t r;
        int p, sh, q, rem, half, e, m;
        r = '0;
        r.stamp = stamp;
        if (v == 11'h000) begin
            r.zero = 1'b1;
            return r;
        end
        p = 0;
        for (int b = 0; b < 11; b++) if (v[b]) p = b;
        e = p + 1;
        if (p >= 3) begin
            sh   = p - 3;
            q    = int'(v) >> sh;
            rem  = int'(v) - (q << sh);
            half = (sh > 0) ? (1 << (sh - 1)) : 0;
            r.inexact = (rem != 0);
            if (rnd && sh > 0 && (rem > half || (rem == half && q[0]))) q = q + 1;
            if (q == 16) begin
                q = 8;
                e = e + 1;
            end
            m = q - 8;
        end else begin
            m = (int'(v) << (3 - p)) - 8;
        end
        if (e > 15) begin
            r.data    = 8'h7F;
            r.ovf     = 1'b1;
            r.inexact = 1'b1;
        end else begin
            r.data = {1'b0, e[3:0], m[2:0]};
        end
        return r;
    endfunction

    // Drive one cycle at the falling edge, then sample all instances 1ns later.
    task automatic step(input logic v, input logic [10:0] d, input logic r, input logic ordy,
                        output logic acc, output obs_t om, output obs_t os, output obs_t og);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_rnd    = r;
        out_ready = ordy;
        #1;
        cyc = cyc + 1;
        acc = v & m_in_ready;
        om  = {m_out_valid & ordy, 1'b0, m_out_data, m_zero, m_inexact, m_ovf};
        os  = {s_out_valid & ordy, 2'b00, s_out_data, s_zero, s_inexact, s_ovf};
        og  = {g_out_valid & ordy, g_out_data, g_zero, g_inexact, g_ovf};
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        q_m.delete();
        q_s.delete();
        q_g.delete();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_rnd    = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({m_out_valid, s_out_valid, g_out_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_valid: got %b want 000", {m_out_valid, s_out_valid, g_out_valid});
        end
        n_checks++;
        if ({m_cnt, s_cnt, g_cnt} !== 48'h0) begin
            n_fail++;
            $display("FAIL reset_count: got %h/%h/%h want 0", m_cnt, s_cnt, g_cnt);
        end
        n_checks++;
        if ({m_out_data, m_zero, m_inexact, m_ovf} !== 10'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h z=%b i=%b o=%b want 0", m_out_data, m_zero,
                     m_inexact, m_ovf);
        end
        n_checks++;
        if ({g_out_data, s_out_data} !== 14'h0) begin
            n_fail++;
            $display("FAIL reset_data_var: got %h/%h want 0", g_out_data, s_out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if ({m_in_ready, s_in_ready, g_in_ready} !== 3'b111) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 111", {m_in_ready, s_in_ready, g_in_ready});
        end
    endtask

    typedef struct packed {
        logic [10:0] din;
        logic        rnd;
        logic [7:0]  data;
        logic [2:0]  flg;
    } vec_t;

    task automatic test_basic();
        vec_t tbl [8] = '{
            '{11'h000, 1'b0, 8'h00, 3'b100},
            '{11'h001, 1'b0, 8'h08, 3'b000},
            '{11'h00B, 1'b0, 8'h23, 3'b000},
            '{11'h017, 1'b1, 8'h2C, 3'b010},
            '{11'h017, 1'b0, 8'h2B, 3'b010},
            '{11'h7FF, 1'b1, 8'h60, 3'b010},
            '{11'h7FF, 1'b0, 8'h5F, 3'b010},
            '{11'h008, 1'b1, 8'h20, 3'b000}
        };
        int   idx = 0;
        vec_t cur;
        logic acc;
        obs_t om, os, og;
        exp_t e;
        for (int c = 0; c < 40 && (idx < 8 || q_m.size() != 0); c++) begin
            cur = (idx < 8) ? tbl[idx] : '0;
            step(idx < 8, cur.din, cur.rnd, 1'b1, acc, om, os, og);
            if (acc) begin
                q_m.push_back({cur.data, cur.flg, cyc});
                idx++;
            end
            if (om.valid) begin
                e = q_m.pop_front();
                n_checks++;
                if ({om.data, om.zero, om.inexact, om.ovf} !== {e.data, e.zero, e.inexact, e.ovf})
                begin
                    n_fail++;
                    $display("FAIL basic_result: got %h z=%b i=%b o=%b want %h z=%b i=%b o=%b",
                             om.data, om.zero, om.inexact, om.ovf, e.data, e.zero, e.inexact,
                             e.ovf);
                end
                n_checks++;
                if (cyc !== e.stamp + 3) begin
                    n_fail++;
                    $display("FAIL basic_latency: got %0d cycles want 3", cyc - e.stamp);
                end
            end
        end
        if (idx < 8 || q_m.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL basic_timeout: got %0d sent %0d pending want 8 sent 0 pending", idx,
                     q_m.size());
        end
        q_m.delete();
    endtask

    typedef struct packed {
        logic [10:0] din;
        logic        rnd;
        logic [7:0]  s_data;
        logic [2:0]  s_flg;
        logic [7:0]  g_data;
        logic [2:0]  g_flg;
    } var_t;

    // Narrow exponent (saturation) and signed instances see the same beats.
    task automatic test_variants();
        var_t tbl [8] = '{
            '{11'h400, 1'b0, 8'h3F, 3'b011, 8'hD8, 3'b000},
            '{11'h07F, 1'b1, 8'h3F, 3'b011, 8'h40, 3'b010},
            '{11'h07F, 1'b0, 8'h3F, 3'b010, 8'h3F, 3'b010},
            '{11'h040, 1'b0, 8'h38, 3'b000, 8'h38, 3'b000},
            '{11'h7FF, 1'b0, 8'h3F, 3'b011, 8'h88, 3'b000},
            '{11'h000, 1'b0, 8'h00, 3'b100, 8'h00, 3'b100},
            '{11'h3FF, 1'b1, 8'h3F, 3'b011, 8'h58, 3'b010},
            '{11'h7FD, 1'b0, 8'h3F, 3'b011, 8'h94, 3'b000}
        };
        int   idx = 0;
        var_t cur;
        logic acc;
        obs_t om, os, og;
        exp_t e;
        apply_reset();
        for (int c = 0; c < 40 && (idx < 8 || q_s.size() != 0 || q_g.size() != 0); c++) begin
            cur = (idx < 8) ? tbl[idx] : '0;
            step(idx < 8, cur.din, cur.rnd, 1'b1, acc, om, os, og);
            if (acc) begin
                q_s.push_back({cur.s_data, cur.s_flg, cyc});
                q_g.push_back({cur.g_data, cur.g_flg, cyc});
                idx++;
            end
            if (os.valid && q_s.size() != 0) begin
                e = q_s.pop_front();
                n_checks++;
                if ({os.data, os.zero, os.inexact, os.ovf} !== {e.data, e.zero, e.inexact, e.ovf})
                begin
                    n_fail++;
                    $display("FAIL sat_result: got %h z=%b i=%b o=%b want %h z=%b i=%b o=%b",
                             os.data, os.zero, os.inexact, os.ovf, e.data, e.zero, e.inexact,
                             e.ovf);
                end
            end
            if (og.valid && q_g.size() != 0) begin
                e = q_g.pop_front();
                n_checks++;
                if ({og.data, og.zero, og.inexact, og.ovf} !== {e.data, e.zero, e.inexact, e.ovf})
                begin
                    n_fail++;
                    $display("FAIL signed_result: got %h z=%b i=%b o=%b want %h z=%b i=%b o=%b",
                             og.data, og.zero, og.inexact, og.ovf, e.data, e.zero, e.inexact,
                             e.ovf);
                end
            end
        end
        if (idx < 8 || q_s.size() != 0 || q_g.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL variants_timeout: got sent=%0d pending=%0d/%0d want 8 0/0", idx,
                     q_s.size(), q_g.size());
        end
    endtask

    task automatic test_backpressure();
        logic [10:0] bp [5] = '{11'h005, 11'h0A0, 11'h123, 11'h7FE, 11'h055};
        int         idx = 0;
        int         n_got = 0;
        int         first_got = 0;
        int         last_got = 0;
        logic       have_snap = 1'b0;
        logic [6:0] snap = '0;
        logic       acc;
        obs_t       om, os, og;
        exp_t       e;
        apply_reset();
        for (int c = 0; c < 5; c++) begin
            step(1'b1, bp[idx], idx[0], 1'b0, acc, om, os, og);
            if (acc) begin
                q_m.push_back(model(bp[idx], idx[0], cyc));
                idx++;
            end
            if (m_out_valid) begin
                if (have_snap) begin
                    n_checks++;
                    if (m_out_data !== snap) begin
                        n_fail++;
                        $display("FAIL bp_hold: got %h want %h", m_out_data, snap);
                    end
                end
                have_snap = 1'b1;
                snap      = m_out_data;
            end
        end
        n_checks++;
        if (idx !== 3) begin
            n_fail++;
            $display("FAIL bp_accepted: got %0d want 3", idx);
        end
        n_checks++;
        if (m_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_in_ready: got %b want 0", m_in_ready);
        end
        for (int c = 0; c < 20 && (idx < 5 || q_m.size() != 0); c++) begin
            step(idx < 5, (idx < 5) ? bp[idx] : 11'h0, idx[0], 1'b1, acc, om, os, og);
            if (acc) begin
                q_m.push_back(model(bp[idx], idx[0], cyc));
                idx++;
            end
            if (om.valid && q_m.size() != 0) begin
                e = q_m.pop_front();
                if (n_got == 0) first_got = cyc;
                last_got = cyc;
                n_got++;
                n_checks++;
                if ({om.data, om.zero, om.inexact, om.ovf} !== {e.data, e.zero, e.inexact, e.ovf})
                begin
                    n_fail++;
                    $display("FAIL bp_result: got %h z=%b i=%b o=%b want %h z=%b i=%b o=%b",
                             om.data, om.zero, om.inexact, om.ovf, e.data, e.zero, e.inexact,
                             e.ovf);
                end
            end
        end
        n_checks++;
        if (n_got !== 5 || last_got - first_got !== 4) begin
            n_fail++;
            $display("FAIL bp_consecutive: got %0d results over %0d cycles want 5 over 4", n_got,
                     last_got - first_got);
        end
        step(1'b0, 11'h0, 1'b0, 1'b1, acc, om, os, og);
        n_checks++;
        if (m_cnt !== 16'd5) begin
            n_fail++;
            $display("FAIL bp_count: got %0d want 5", m_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int          sent = 0;
        int          n_got = 0;
        logic [10:0] d;
        logic        r;
        logic        acc;
        obs_t        om, os, og;
        exp_t        e;
        apply_reset();
        d = 11'($urandom_range(0, 2047));
        r = 1'($urandom_range(0, 1));
        for (int c = 0; c < 300 && (sent < 40 || q_m.size() != 0); c++) begin
            step(sent < 40, d, r, $urandom_range(0, 3) != 0, acc, om, os, og);
            if (acc) begin
                q_m.push_back(model(d, r, cyc));
                sent++;
                d = 11'($urandom_range(0, 2047));
                r = 1'($urandom_range(0, 1));
            end
            if (om.valid) begin
                n_checks++;
                if (q_m.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_extra: got %h want no result", om.data);
                end else begin
                    e = q_m.pop_front();
                    n_got++;
                    if ({om.data, om.zero, om.inexact, om.ovf} !==
                        {e.data, e.zero, e.inexact, e.ovf}) begin
                        n_fail++;
                        $display("FAIL b2b_result: got %h z=%b i=%b o=%b want %h z=%b i=%b o=%b",
                                 om.data, om.zero, om.inexact, om.ovf, e.data, e.zero,
                                 e.inexact, e.ovf);
                    end
                end
            end
        end
        step(1'b0, 11'h0, 1'b0, 1'b1, acc, om, os, og);
        n_checks++;
        if (n_got !== 40 || m_cnt !== 16'd40) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d results count=%0d want 40 count=40", n_got, m_cnt);
        end
    endtask

    task automatic test_reset_midop();
        int   n_stale = 0;
        logic acc;
        obs_t om, os, og;
        step(1'b1, 11'h00B, 1'b0, 1'b1, acc, om, os, og);
        step(1'b1, 11'h017, 1'b1, 1'b1, acc, om, os, og);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (m_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_valid: got %b want 0", m_out_valid);
        end
        n_checks++;
        if (m_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL midrst_count: got %0d want 0", m_cnt);
        end
        rst_n = 1'b1;
        q_m.delete();
        for (int c = 0; c < 6; c++) begin
            step(1'b0, 11'h0, 1'b0, 1'b1, acc, om, os, og);
            if (om.valid) n_stale++;
        end
        n_checks++;
        if (n_stale !== 0) begin
            n_fail++;
            $display("FAIL midrst_stale: got %0d results want 0", n_stale);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_variants();
        test_backpressure();
        test_back_to_back();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
